mem_arbiter: RTL
================

# mem_arbiter

Two-port arbiter that shares one single-port unified instruction/data memory between the RV32i pipeline's fetch stage and its memory stage. It grants the bus to one requester at a time and drives a registered request to the memory. It waits out variable memory latency, with an optional timeout. While a port's access is outstanding, it asserts that port's stall toward the hazard logic.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 255, maximum cycles to wait for `mem_ready` per access (0 = no timeout); counter width $clog2(TIMEOUT+1)

Ports:
- clk  in  1  clock; all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request; held until the `if_valid` cycle
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetch data, valid when `if_valid`
- if_valid  out  1  one-cycle completion pulse for fetch
- if_err  out  1  fetch timed out; only with `if_valid`
- stall_f  out  1  fetch access outstanding
- dm_req  in  1  data request; held until the `dm_valid` cycle
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_wmask  in  DATA_W/8  byte enables for stores
- dm_rdata  out  DATA_W  load data, valid when `dm_valid`
- dm_valid  out  1  one-cycle completion pulse for data
- dm_err  out  1  data access timed out; only with `dm_valid`
- stall_m  out  1  data access outstanding
- mem_req  out  1  memory request, held until accepted
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_wmask  out  DATA_W/8  memory byte enables
- mem_ready  in  1  memory completes the current access this cycle
- mem_rdata  in  DATA_W  read data, valid with `mem_ready`

## Operation
- FSM states are IDLE, BUS_IF and BUS_DM. The `last_dm` flag records whether the most recent grant went to the data port.
- **IDLE, grant to data:** if `dm_req & (~if_req | ~last_dm)`, go to BUS_DM.
  - Register `mem_req=1`, `mem_we=dm_we`, and `dm_addr`/`dm_wdata`/`dm_wmask`.
  - Set `last_dm=1`.
- **IDLE, grant to fetch:** else if `if_req`, go to BUS_IF.
  - Register `mem_req=1`, `mem_we=0`, `mem_wmask=0`, `mem_addr=if_addr`.
  - Set `last_dm=0`.
- **Arbitration outcome:** the data port wins ties unless it won the previous grant. With both requests held continuously, grants alternate DM, IF, DM, IF, so neither port starves.
- **BUS_x completion:** when `mem_ready=1`:
  - `x_valid=1` combinationally that cycle, and `x_rdata=mem_rdata` (pass-through).
  - Next state is IDLE, with `mem_req`, `mem_we` and `mem_wmask` cleared. `mem_addr` and `mem_wdata` keep their last values.
- **Timeout:** a wait counter clears on grant and increments each BUS cycle without `mem_ready`.
  - If TIMEOUT≠0 and the counter reaches TIMEOUT-1 with `mem_ready=0`, the access ends: `x_valid=1`, `x_err=1`, `x_rdata=0`, next state IDLE.
  - The memory must tolerate the abandoned request.
- **Stalls:**
  - `stall_f = if_req & ~if_valid`
  - `stall_m = dm_req & ~dm_valid`
  - These are combinational and therefore also high while the port waits in IDLE behind the other grant.
- **Outside completion cycles:** `if_rdata`/`dm_rdata` read 0 whenever the corresponding valid is low.
- **Request changes during an access:** a request dropped or changed mid-access does not affect the access in flight, because its inputs were registered at grant.
- **`mem_ready` outside BUS states:** ignored.

## Timing
- **Reset (asynchronous, `reset_n=0`):**
  - State IDLE, `last_dm=0`, counter 0.
  - `mem_req=0`, `mem_we=0`, `mem_addr=0`, `mem_wdata=0`, `mem_wmask=0`.
  - All valid, err and stall-driven outputs are 0 (stalls follow the requests).
  - Reset during BUS_x aborts the access immediately with no valid pulse.
- **Minimum latency:** request sampled in IDLE at edge N, `mem_req` high in cycle N+1. If `mem_ready=1` in cycle N+1, valid pulses in cycle N+1 (2-cycle access).
- **Wait states:** each cycle of `mem_ready=0` adds one cycle.
- **Bus turnaround:** there is always one IDLE cycle between consecutive accesses, so back-to-back throughput is one access per 2 cycles at zero wait.
- **Timeout completion:** a timed-out access completes exactly TIMEOUT cycles after `mem_req` rises.

## Test plan
- **Single fetch:** `if_req=1`, `if_addr=0x100`, memory ready immediately with `0x00500093` → `mem_req` high in cycle 1, `if_valid=1` in cycle 1 with `if_rdata=0x00500093`, `stall_f` high in cycle 0 only.
- **Store with 3 wait states:** `dm_we=1`, `dm_addr=0x2004`, `dm_wmask=0xC`, `dm_wdata=0xDEADBEEF` → `mem_we=1`, `mem_wmask=0xC` held for 4 cycles, `dm_valid` in cycle 4, `stall_m` high in cycles 0–3.
- **Contention:** `if_req` and `dm_req` held together after reset → grant order DM, IF, DM, IF. Each IDLE cycle shows the losing port's stall high.
- **Timeout:** TIMEOUT=8, `mem_ready` held 0 → `dm_valid=1`, `dm_err=1`, `dm_rdata=0` 8 cycles after `mem_req` rises; next access proceeds normally.
- **Reset mid-access:** `reset_n` low during BUS_IF wait → `mem_req` drops asynchronously, no `if_valid`. After release the FSM is in IDLE and the held `if_req` is re-granted.
- **Stray `mem_ready`:** `mem_ready=1` pulsed in IDLE with no requests → no valid pulse, no state change.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port unified memory between the fetch and data ports.
// Grants one registered request at a time, with alternating priority and an optional timeout.
module mem_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset_n,
    // fetch port
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_valid,
    output logic                if_err,
    output logic                stall_f,
    // data port
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    input  logic [DATA_W/8-1:0] dm_wmask,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                dm_valid,
    output logic                dm_err,
    output logic                stall_m,
    // memory side
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_ready,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int unsigned MaskW = DATA_W / 8;
    // A zero TIMEOUT still needs a 1-bit counter so the logic stays well-formed.
    localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CntW-1:0] CntLast = (TIMEOUT > 0) ? CntW'(TIMEOUT - 1) : '0;
    localparam logic TimeoutEn = (TIMEOUT > 0);

    typedef enum logic [1:0] {
        StIdle,
        StBusIf,
        StBusDm
    } state_e;

    state_e              state_q, state_d;
    logic                last_dm_q, last_dm_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [MaskW-1:0]    mem_wmask_q, mem_wmask_d;

    logic busy;
    logic timeout_hit;
    logic done;

    always_comb begin
        busy        = (state_q != StIdle);
        timeout_hit = TimeoutEn && busy && !mem_ready && (cnt_q == CntLast);
        done        = busy && (mem_ready || timeout_hit);
    end

    always_comb begin
        state_d     = state_q;
        last_dm_d   = last_dm_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wmask_d = mem_wmask_q;

        case (state_q)
            StIdle: begin
                // Data wins ties unless it took the previous grant.
                if (dm_req && (!if_req || !last_dm_q)) begin
                    state_d     = StBusDm;
                    last_dm_d   = 1'b1;
                    cnt_d       = '0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = dm_we;
                    mem_addr_d  = dm_addr;
                    mem_wdata_d = dm_wdata;
                    mem_wmask_d = dm_wmask;
                end else if (if_req) begin
                    state_d     = StBusIf;
                    last_dm_d   = 1'b0;
                    cnt_d       = '0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_wmask_d = '0;
                end
            end
            StBusIf, StBusDm: begin
                if (done) begin
                    state_d     = StIdle;
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_wmask_d = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            last_dm_q   <= 1'b0;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wmask_q <= '0;
        end else begin
            state_q     <= state_d;
            last_dm_q   <= last_dm_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wmask_q <= mem_wmask_d;
        end
    end

    // Completion is combinational; read data is zeroed on timeout and outside completion.
    always_comb begin
        if_valid = (state_q == StBusIf) && done;
        dm_valid = (state_q == StBusDm) && done;
        if_err   = if_valid && !mem_ready;
        dm_err   = dm_valid && !mem_ready;
        if_rdata = (if_valid && mem_ready) ? mem_rdata : '0;
        dm_rdata = (dm_valid && mem_ready) ? mem_rdata : '0;
        stall_f  = if_req && !if_valid;
        stall_m  = dm_req && !dm_valid;
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wmask = mem_wmask_q;

endmodule
